// File: rtl/cdc_sched_pkg.sv
// Shared definitions for the dmux_cdc transmit scheduler and its benches.
// Keeping the default timing constants here keeps both sides of the crossing in agreement.
package cdc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } sched_state_e;

  localparam int DEF_HOLD_CYCLES = 10;
  localparam int DEF_GAP_CYCLES  = 20;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: the first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               any
);

  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = IW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_tx_sched.sv
// Fast-domain transmit scheduler for dmux_cdc: round-robin grant, then a fixed-length
// valid pulse followed by a guaranteed low gap so the slow side can sample and settle.
module cdc_tx_sched
  import cdc_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                          clk_f,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          valid_in,
  output logic                          busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

  sched_state_e state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]         gnt_id_q, gnt_id_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] words;
  logic [NUM_REQ-1:0]                 pick_oh;
  logic [IW-1:0]                      pick_idx;
  logic                               pick_any;
  logic                               arb;

  assign words = req_data;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_d    = '0;
    gnt_id_d = gnt_id_q;
    data_d   = data_q;
    valid_d  = valid_q;
    arb      = 1'b0;

    case (state_q)
      IDLE: arb = pick_any;
      HOLD: begin
        if (cnt_q == '0) begin
          valid_d = 1'b0;
          cnt_d   = GAP_LD;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        // Gap expiry with a pending request chains straight into the next word.
        if (cnt_q == '0) begin
          if (pick_any) arb = 1'b1;
          else          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (arb) begin
      data_d   = words[pick_idx];
      valid_d  = 1'b1;
      gnt_d    = pick_oh;
      gnt_id_d = pick_idx;
      ptr_d    = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
      cnt_d    = HOLD_LD;
      state_d  = HOLD;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_f or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_id   = gnt_id_q;
  assign data_in  = data_q;
  assign valid_in = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_cdc_tx_sched.sv
// Bench for cdc_tx_sched: directed scenarios plus random traffic, checked every cycle
// against a timeline model (last grant edge, pointer, last word).
module tb_cdc_tx_sched;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int H  = 10;
  localparam int G  = 20;

  logic            clk_f = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    gnt;
  logic [1:0]      gnt_id;
  logic [DW-1:0]   data_in;
  logic            valid_in;
  logic            busy;

  int errors = 0;
  int checks = 0;

  // Model: edge counter since reset, edge of last grant, pointer, last winner/word.
  int            t, t_g, m_ptr, m_id;
  bit            have_g;
  logic [DW-1:0] m_data;

  logic [15:0] act_vec;
  assign act_vec = {gnt, gnt_id, data_in, valid_in, busy};

  cdc_tx_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk_f(clk_f), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .gnt_id(gnt_id), .data_in(data_in), .valid_in(valid_in), .busy(busy)
  );

  always #5 clk_f = ~clk_f;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    t = 0; t_g = 0; have_g = 0; m_ptr = 0; m_id = 0; m_data = '0;
  endtask

  function automatic logic [15:0] exp_vec();
    logic [N-1:0] g;
    int d;
    g = '0;
    d = t - t_g;
    if (have_g && d == 0) g[m_id] = 1'b1;
    return {g, 2'(m_id), m_data, 1'(have_g && d < H), 1'(have_g && d < H + G)};
  endfunction

  // One clock edge: model consumes the inputs present at the edge, then settle 1 ns.
  task automatic tick();
    int w;
    @(posedge clk_f);
    if (rst_n) begin
      t++;
      if ((!have_g || (t - t_g) >= H + G) && (|req)) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        t_g = t; have_g = 1; m_id = w;
        m_data = req_data[w*DW +: DW];
        m_ptr = (w + 1) % N;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset();
    req = 4'b1111;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (10) tick();
    checks++;
    if ({gnt, gnt_id, data_in, valid_in, busy} !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0000", act_vec);
    end
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || valid_in !== 1'b1 || data_in !== 8'h11) begin
      errors++; $display("FAIL first_grant: gnt=%b id=%0d valid=%b data=%h expected 0001/0/1/11", gnt, gnt_id, valid_in, data_in);
    end
    req = '0;
    for (int c = 0; c < H + G + 2; c++) begin
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL reset_drain cycle %0d: got %h expected %h", c, act_vec, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_single();
    int hi_cnt, busy_cnt;
    bit got;
    got = 0;
    req_data[2*DW +: DW] = 8'hA5;
    req = 4'b0100;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL single_wait cycle %0d: got %h expected %h", c, act_vec, exp_vec());
      end
      if (gnt !== '0) got = 1;
    end
    checks++;
    if (!got || gnt !== 4'b0100 || gnt_id !== 2'd2 || data_in !== 8'hA5) begin
      errors++; $display("FAIL single_grant: got=%0d gnt=%b id=%0d data=%h expected 0100/2/a5", got, gnt, gnt_id, data_in);
    end
    req = '0;
    hi_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      if (valid_in === 1'b1) begin
        hi_cnt++;
        checks++;
        if (data_in !== 8'hA5) begin
          errors++; $display("FAIL single_data cycle %0d: got %h expected a5", c, data_in);
        end
      end
      if (busy === 1'b1) busy_cnt++;
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL single_cycle %0d: got %h expected %h", c, act_vec, exp_vec());
      end
    end
    checks++;
    if (hi_cnt != H) begin errors++; $display("FAIL single_hold_len: got %0d expected %0d", hi_cnt, H); end
    checks++;
    if (busy_cnt != H + G) begin errors++; $display("FAIL single_busy_len: got %0d expected %0d", busy_cnt, H + G); end
  endtask

  task automatic test_round_robin();
    int ids[5];
    int rise[5];
    int n;
    logic prev_v;
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    n = 0; prev_v = 1'b0;
    for (int c = 0; c < 200 && n < 5; c++) begin
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL rr_cycle %0d: got %h expected %h", c, act_vec, exp_vec());
      end
      if (valid_in === 1'b1 && prev_v === 1'b0) begin
        ids[n] = int'(gnt_id); rise[n] = c;
        checks++;
        if (data_in !== 8'(8'h11 * (gnt_id + 1))) begin
          errors++; $display("FAIL rr_data: id=%0d got %h", gnt_id, data_in);
        end
        n++;
      end
      prev_v = valid_in;
    end
    req = '0;
    checks++;
    if (n != 5 || ids[0] != 0 || ids[1] != 1 || ids[2] != 2 || ids[3] != 3 || ids[4] != 0) begin
      errors++; $display("FAIL rr_order: got n=%0d %0d %0d %0d %0d %0d expected 0 1 2 3 0", n, ids[0], ids[1], ids[2], ids[3], ids[4]);
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (i < n && rise[i] - rise[i-1] != H + G) begin
        errors++; $display("FAIL rr_spacing %0d: got %0d expected %0d", i, rise[i] - rise[i-1], H + G);
      end
    end
    repeat (H + G + 2) tick();
  endtask

  task automatic test_wrap();
    int ids[6];
    int tg[6];
    int n;
    do_reset();
    req_data = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    req = 4'b0100;
    n = 0;
    for (int c = 0; c < 300 && n < 6; c++) begin
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL wrap_cycle %0d: got %h expected %h", c, act_vec, exp_vec());
      end
      if (gnt !== '0) begin
        ids[n] = int'(gnt_id); tg[n] = c; n++;
        if (n == 1) req = 4'b1001;
        if (n == 3) req = 4'b0001;
      end
    end
    req = '0;
    checks++;
    if (n != 6 || ids[0] != 2 || ids[1] != 3 || ids[2] != 0 || ids[3] != 0 || ids[4] != 0 || ids[5] != 0) begin
      errors++; $display("FAIL wrap_order: n=%0d got %0d %0d %0d %0d %0d %0d expected 2 3 0 0 0 0", n, ids[0], ids[1], ids[2], ids[3], ids[4], ids[5]);
    end
    checks++;
    if (n == 6 && (tg[5] - tg[4] != H + G || tg[4] - tg[3] != H + G)) begin
      errors++; $display("FAIL wrap_period: got %0d/%0d expected %0d", tg[4] - tg[3], tg[5] - tg[4], H + G);
    end
    repeat (H + G + 2) tick();
  endtask

  task automatic test_mid_reset();
    bit got;
    do_reset();
    req_data = {8'h04, 8'h03, 8'h5C, 8'h01};
    req = 4'b0110;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (gnt !== '0) got = 1;
    end
    checks++;
    if (!got || gnt_id !== 2'd1) begin
      errors++; $display("FAIL midrst_first: got=%0d id=%0d expected 1", got, gnt_id);
    end
    repeat (4) tick();
    checks++;
    if (valid_in !== 1'b1) begin errors++; $display("FAIL midrst_hold: valid=%b expected 1", valid_in); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({gnt, gnt_id, data_in, valid_in, busy} !== 16'h0) begin
      errors++; $display("FAIL midrst_async: got %h expected 0000", act_vec);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1 || data_in !== 8'h5C || valid_in !== 1'b1) begin
      errors++; $display("FAIL midrst_regrant: gnt=%b id=%0d data=%h expected 0010/1/5c", gnt, gnt_id, data_in);
    end
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++; $display("FAIL midrst_model: got %h expected %h", act_vec, exp_vec());
    end
    req = '0;
    repeat (H + G + 2) tick();
  endtask

  task automatic test_random();
    int grants;
    do_reset();
    req = '0;
    grants = 0;
    for (int c = 0; c < 1200; c++) begin
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL random_cycle %0d: got %h expected %h", c, act_vec, exp_vec());
      end
      if (gnt !== '0) grants++;
      for (int i = 0; i < N; i++) begin
        if (req[i] && gnt[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          req_data[i*DW +: DW] = 8'($urandom);
        end else if (!req[i]) begin
          if ($urandom_range(0, 7) == 0) begin
            req[i] = 1'b1;
            req_data[i*DW +: DW] = 8'($urandom);
          end
        end else if ($urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    checks++;
    if (grants < 10) begin errors++; $display("FAIL random_activity: got %0d grants expected >= 10", grants); end
    repeat (H + G + 2) tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
